// File: rtl/core_pkg.sv
// Shared front-end definitions for the two-stage RV32I core: PC unit state
// encoding, instruction size, default boot address and small PC helpers.
package core_pkg;

  typedef enum logic [1:0] {
    PCU_BOOT   = 2'd0,
    PCU_RUN    = 2'd1,
    PCU_REFILL = 2'd2
  } pcu_state_t;

  localparam logic [31:0] INSN_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [31:0] seqPc(input logic [31:0] pc);
    return pc + INSN_BYTES;
  endfunction

  function automatic logic isMisaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Signal bundle between the PC redirect unit (slave) and the surrounding
// core: XB redirect sources, csr_ehu trap controls and the fetch/stage view.
interface pc_redirect_unit_if;

  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mret;
  logic        initiate_exception;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] imem_addr;
  logic [31:0] FD_pc;
  logic        FD_bubble;
  logic [31:0] XB_pc;
  logic        XB_bubble;
  logic        XB_FD_exception_instruction_misaligned;

  modport slave (
    input  stall, branch_taken, branch_target, mret,
    input  initiate_exception, csr_mtvec, csr_mepc,
    output imem_addr, FD_pc, FD_bubble, XB_pc, XB_bubble,
    output XB_FD_exception_instruction_misaligned
  );

  modport master (
    output stall, branch_taken, branch_target, mret,
    output initiate_exception, csr_mtvec, csr_mepc,
    input  imem_addr, FD_pc, FD_bubble, XB_pc, XB_bubble,
    input  XB_FD_exception_instruction_misaligned
  );

endinterface

// File: rtl/pc_next_mux.sv
// Priority selector for the next fetch address (trap > mret > branch > hold > +4).
// PC_MISALIGN_CHECK_EN turns misaligned branch targets into an XB exception.
module pc_next_mux
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  pcu_state_t  i_state,
  input  logic        i_stall,
  input  logic        i_branchTaken,
  input  logic [31:0] i_branchTarget,
  input  logic        i_mret,
  input  logic        i_initiateException,
  input  logic [31:0] i_csrMtvec,
  input  logic [31:0] i_csrMepc,
  input  logic        i_xbBubble,
  input  logic [31:0] i_fdPc,
  output logic [31:0] o_imemAddr,
  output logic        o_redirect,
  output logic        o_misalign
);

  logic        w_xbLive;
  logic        w_branchLive;
  logic        w_mretLive;
  logic        w_targetBad;
  logic [31:0] w_target;

  // XB-originated redirects need a real instruction in XB and a moving pipe.
  assign w_xbLive     = !i_xbBubble && !i_stall;
  assign w_branchLive = i_branchTaken && w_xbLive;
  assign w_mretLive   = i_mret && w_xbLive;

`ifdef PC_MISALIGN_CHECK_EN
  assign w_target    = i_branchTarget;
  assign w_targetBad = isMisaligned(i_branchTarget);
`else
  logic w_unusedTargetBits;
  assign w_target           = {i_branchTarget[31:2], 2'b00};
  assign w_targetBad        = 1'b0;
  assign w_unusedTargetBits = ^i_branchTarget[1:0];
`endif

  always_comb begin
    o_imemAddr = seqPc(i_fdPc);
    o_redirect = 1'b0;
    o_misalign = 1'b0;
    if (i_state == PCU_BOOT) begin
      o_imemAddr = RESET_PC;
    end else if (i_initiateException) begin
      o_imemAddr = i_csrMtvec;
      o_redirect = 1'b1;
    end else if (w_mretLive) begin
      o_imemAddr = i_csrMepc;
      o_redirect = 1'b1;
    end else if (w_branchLive && !w_targetBad) begin
      o_imemAddr = w_target;
      o_redirect = 1'b1;
    end else if (w_branchLive) begin
      // Bad target: keep fetching in place and let csr_ehu trap from XB.
      o_imemAddr = i_fdPc;
      o_misalign = 1'b1;
    end else if (i_stall || i_state == PCU_REFILL) begin
      o_imemAddr = i_fdPc;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner and FD->XB stage register for the two-stage iCE40 RV32I core.
// Optional macro PC_MISALIGN_CHECK_EN enables misaligned branch-target traps.
module pc_redirect_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   resetb,
  pc_redirect_unit_if.slave      io_pcu
);

  pcu_state_t  r_state;
  pcu_state_t  w_nextState;
  logic [31:0] r_fdPc;
  logic [31:0] r_xbPc;
  logic        r_xbBubble;
  logic [31:0] w_imemAddr;
  logic        w_redirect;
  logic        w_misalign;
  logic        w_flush;
  logic        w_fdBubble;

  pc_next_mux #(
    .RESET_PC (RESET_PC)
  ) u_pcNextMux (
    .i_state             (r_state),
    .i_stall             (io_pcu.stall),
    .i_branchTaken       (io_pcu.branch_taken),
    .i_branchTarget      (io_pcu.branch_target),
    .i_mret              (io_pcu.mret),
    .i_initiateException (io_pcu.initiate_exception),
    .i_csrMtvec          (io_pcu.csr_mtvec),
    .i_csrMepc           (io_pcu.csr_mepc),
    .i_xbBubble          (r_xbBubble),
    .i_fdPc              (r_fdPc),
    .o_imemAddr          (w_imemAddr),
    .o_redirect          (w_redirect),
    .o_misalign          (w_misalign)
  );

  assign w_flush    = w_redirect | w_misalign;
  assign w_fdBubble = (r_state != PCU_RUN);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= PCU_BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // REFILL holds the PC for one cycle so the BRAM word lines up with FD_pc.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      PCU_BOOT:   w_nextState = PCU_REFILL;
      PCU_REFILL: w_nextState = w_flush ? PCU_REFILL : PCU_RUN;
      PCU_RUN:    w_nextState = w_flush ? PCU_REFILL : PCU_RUN;
      default:    w_nextState = PCU_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_fdPc <= RESET_PC;
    end else begin
      r_fdPc <= w_imemAddr;
    end
  end

  // A redirect kills the slot entering XB even while the pipe is stalled.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_xbPc     <= 32'h0;
      r_xbBubble <= 1'b1;
    end else if (w_redirect) begin
      r_xbBubble <= 1'b1;
      if (!io_pcu.stall) begin
        r_xbPc <= r_fdPc;
      end
    end else if (w_misalign) begin
      r_xbBubble <= 1'b0;
    end else if (!io_pcu.stall) begin
      r_xbPc     <= r_fdPc;
      r_xbBubble <= w_fdBubble;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic r_xbMisaligned;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_xbMisaligned <= 1'b0;
    end else if (w_misalign) begin
      r_xbMisaligned <= 1'b1;
    end else if (w_redirect || !io_pcu.stall) begin
      r_xbMisaligned <= 1'b0;
    end
  end

  assign io_pcu.XB_FD_exception_instruction_misaligned = r_xbMisaligned;
`else
  assign io_pcu.XB_FD_exception_instruction_misaligned = 1'b0;
`endif

  assign io_pcu.imem_addr = w_imemAddr;
  assign io_pcu.FD_pc     = r_fdPc;
  assign io_pcu.FD_bubble = w_fdBubble;
  assign io_pcu.XB_pc     = r_xbPc;
  assign io_pcu.XB_bubble = r_xbBubble;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed + random bench for pc_redirect_unit against a cycle-level model
// of the fetch/XB rules; honours PC_MISALIGN_CHECK_EN like the design.
module tb_pc_redirect_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic resetb;
  int   checks = 0;
  int   errors = 0;

  // Model of the pipeline front end, expressed as "slots until FD is valid".
  logic [31:0] mPc;
  logic [31:0] mXbPc;
  logic        mXbBubble;
  logic        mFlag;
  logic        mBoot;
  int          refillLeft;
  logic [31:0] eImem;
  logic        eRedir;
  logic        eMis;

  pc_redirect_unit_if bus ();

  pc_redirect_unit #(
    .RESET_PC (TB_RESET_PC)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .io_pcu (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelResetState();
    mPc        = TB_RESET_PC;
    mXbPc      = 32'h0;
    mXbBubble  = 1'b1;
    mFlag      = 1'b0;
    mBoot      = 1'b1;
    refillLeft = 2;
  endtask

  task automatic modelPredict();
    logic        xbOk;
    logic [31:0] tgt;
    logic        bad;
    xbOk   = !mXbBubble && !bus.stall;
    eRedir = 1'b0;
    eMis   = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    tgt = bus.branch_target;
    bad = (bus.branch_target % 4) != 0;
`else
    tgt = bus.branch_target - (bus.branch_target % 4);
    bad = 1'b0;
`endif
    if (mBoot) eImem = TB_RESET_PC;
    else if (bus.initiate_exception) begin eImem = bus.csr_mtvec; eRedir = 1'b1; end
    else if (bus.mret && xbOk) begin eImem = bus.csr_mepc; eRedir = 1'b1; end
    else if (bus.branch_taken && xbOk && !bad) begin eImem = tgt; eRedir = 1'b1; end
    else if (bus.branch_taken && xbOk) begin eImem = mPc; eMis = 1'b1; end
    else if (bus.stall || refillLeft > 0) eImem = mPc;
    else eImem = mPc + 4;
  endtask

  task automatic checkOutput();
    modelPredict();
    check("imem_addr", bus.imem_addr, eImem);
    check("FD_pc", bus.FD_pc, mPc);
    check("FD_bubble", {31'b0, bus.FD_bubble}, {31'b0, refillLeft > 0});
    check("XB_pc", bus.XB_pc, mXbPc);
    check("XB_bubble", {31'b0, bus.XB_bubble}, {31'b0, mXbBubble});
    check("misalignFlag", {31'b0, bus.XB_FD_exception_instruction_misaligned}, {31'b0, mFlag});
  endtask

  task automatic modelEdge();
    logic fdWasBubble;
    fdWasBubble = refillLeft > 0;
    if (eRedir) begin
      mXbBubble = 1'b1;
      mFlag     = 1'b0;
      if (!bus.stall) mXbPc = mPc;
    end else if (eMis) begin
      mXbBubble = 1'b0;
      mFlag     = 1'b1;
    end else if (!bus.stall) begin
      mXbPc     = mPc;
      mXbBubble = fdWasBubble;
      mFlag     = 1'b0;
    end
    mPc = eImem;
    if (eRedir || eMis) refillLeft = 1;
    else if (refillLeft > 0) refillLeft--;
    mBoot = 1'b0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic applyStimulus(input logic st, input logic bt, input logic [31:0] btgt,
                               input logic mr, input logic exc,
                               input logic [31:0] mtvec, input logic [31:0] mepc);
    bus.stall              = st;
    bus.branch_taken       = bt;
    bus.branch_target      = btgt;
    bus.mret               = mr;
    bus.initiate_exception = exc;
    bus.csr_mtvec          = mtvec;
    bus.csr_mepc           = mepc;
    #1;
    checkOutput();
    modelEdge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0; bus.mret = 0;
    bus.initiate_exception = 0; bus.csr_mtvec = 0; bus.csr_mepc = 0;
    resetb = 1'b0;
    #1;
    modelResetState();
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  initial begin
    logic        st, bt, mr, exc;
    logic [31:0] tgt, mtvec, mepc, savedXbPc, savedPc;
    int          r;

    resetb = 1'b0;
    @(negedge clk);
    doReset();

    $display("[TB] reset release and sequential fetch");
    idle(1);
    check("boot1FdPc", bus.FD_pc, 32'h0);
    check("boot1FdBub", {31'b0, bus.FD_bubble}, 32'h1);
    idle(1);
    check("boot2FdPc", bus.FD_pc, 32'h0);
    check("boot2FdBub", {31'b0, bus.FD_bubble}, 32'h0);
    check("boot2XbBub", {31'b0, bus.XB_bubble}, 32'h1);
    idle(1);
    check("boot3FdPc", bus.FD_pc, 32'h4);
    check("boot3XbBub", {31'b0, bus.XB_bubble}, 32'h0);
    check("boot3XbPc", bus.XB_pc, 32'h0);
    idle(1);
    check("boot4FdPc", bus.FD_pc, 32'h8);

    $display("[TB] branch from XB_pc 0x10 to 0x100");
    for (int k = 0; k < 20 && !(mXbPc == 32'h10 && !mXbBubble); k++) idle(1);
    applyStimulus(0, 1, 32'h100, 0, 0, 32'h0, 32'h0);
    check("brFdPc", bus.FD_pc, 32'h100);
    check("brFdBub", {31'b0, bus.FD_bubble}, 32'h1);
    check("brXbBub1", {31'b0, bus.XB_bubble}, 32'h1);
    idle(1);
    check("brFdValid", {31'b0, bus.FD_bubble}, 32'h0);
    check("brXbBub2", {31'b0, bus.XB_bubble}, 32'h1);
    idle(1);
    check("brXbPc", bus.XB_pc, 32'h100);
    check("brXbValid", {31'b0, bus.XB_bubble}, 32'h0);

    $display("[TB] stall held three cycles at 0x20");
    applyStimulus(0, 1, 32'h18, 0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 20 && !(mPc == 32'h20 && refillLeft == 0); k++) idle(1);
    savedXbPc = mXbPc;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
      check("stallFdPc", bus.FD_pc, 32'h20);
      check("stallXbPc", bus.XB_pc, savedXbPc);
      check("stallXbBub", {31'b0, bus.XB_bubble}, 32'h0);
    end
    idle(1);
    check("stallResume", bus.FD_pc, 32'h24);

    $display("[TB] trap under stall, then priority collision");
    applyStimulus(1, 0, 32'h0, 0, 1, 32'h4, 32'h0);
    check("trapFdPc", bus.FD_pc, 32'h4);
    check("trapFdBub", {31'b0, bus.FD_bubble}, 32'h1);
    check("trapXbBub", {31'b0, bus.XB_bubble}, 32'h1);
    idle(3);
    applyStimulus(0, 1, 32'h100, 1, 1, 32'h40, 32'h200);
    check("prioFdPc", bus.FD_pc, 32'h40);
    idle(3);
    applyStimulus(0, 1, 32'h100, 1, 0, 32'h40, 32'h200);
    check("mretFdPc", bus.FD_pc, 32'h200);

    $display("[TB] PC wrap at top of address space");
    idle(3);
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0);
    idle(2);
    check("wrapFdPc", bus.FD_pc, 32'h0);

    $display("[TB] branch to misaligned 0x102");
    for (int k = 0; k < 10 && mXbBubble; k++) idle(1);
    savedXbPc = mXbPc;
    savedPc   = mPc;
    applyStimulus(0, 1, 32'h102, 0, 0, 32'h0, 32'h0);
`ifdef PC_MISALIGN_CHECK_EN
    check("misFlag", {31'b0, bus.XB_FD_exception_instruction_misaligned}, 32'h1);
    check("misXbPc", bus.XB_pc, savedXbPc);
    check("misXbBub", {31'b0, bus.XB_bubble}, 32'h0);
    check("misFdPc", bus.FD_pc, savedPc);
`else
    check("misFdPc", bus.FD_pc, 32'h100);
    check("misFlag", {31'b0, bus.XB_FD_exception_instruction_misaligned}, 32'h0);
`endif

    $display("[TB] reset during a redirect");
    idle(3);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h300;
    #2 resetb = 1'b0;
    #1;
    check("rstFdPc", bus.FD_pc, TB_RESET_PC);
    check("rstXbBub", {31'b0, bus.XB_bubble}, 32'h1);
    check("rstImem", bus.imem_addr, TB_RESET_PC);
    @(negedge clk);
    doReset();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
        continue;
      end
      st    = ($urandom_range(0, 3) == 0);
      bt    = ($urandom_range(0, 4) == 0);
      mr    = ($urandom_range(0, 19) == 0);
      exc   = ($urandom_range(0, 19) == 0);
      tgt   = $urandom;
      tgt[1:0] = 2'b00;
      r     = $urandom_range(0, 15);
      if (r == 0) tgt = 32'hFFFF_FFFC;
      else if (r < 3) tgt[1:0] = 2'($urandom_range(1, 3));
      mtvec = $urandom;
      mtvec[1:0] = 2'b00;
      mepc  = $urandom;
      mepc[1:0] = 2'b00;
      applyStimulus(st, bt, tgt, mr, exc, mtvec, mepc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Front-end PC generator and FD→XB stage register for the two-stage iCE40 RV32I pipeline. It owns the fetch PC, drives the synchronous instruction-memory address, and tracks bubbles through FD and XB. It selects the next PC from sequential, branch/jump, `mret` and trap sources. It feeds `XB_pc`, `XB_bubble` and the instruction-misaligned flag to `csr_ehu`, and consumes `initiate_exception`, `csr_mtvec` and `csr_mepc` from it.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: clock.
- `resetb`  in  1: reset, asynchronous, active-low.
- `stall`  in  1: hold FD and XB; no PC advance.
- `branch_taken`  in  1: XB instruction redirects; qualified by `!XB_bubble`.
- `branch_target`  in  32: redirect address from the XB ALU.
- `mret`  in  1: XB instruction is `mret`; qualified by `!XB_bubble`.
- `initiate_exception`  in  1: trap request from `csr_ehu`.
- `csr_mtvec`  in  32: trap vector.
- `csr_mepc`  in  32: `mret` return address.
- `imem_addr`  out  32: combinational next-PC to synchronous BRAM (1-cycle read).
- `FD_pc`  out  32: PC of the instruction currently presented in FD.
- `FD_bubble`  out  1: FD slot invalid.
- `XB_pc`  out  32: PC of the XB instruction.
- `XB_bubble`  out  1: XB slot invalid.
- `XB_FD_exception_instruction_misaligned`  out  1: XB slot carries a misaligned-target exception.

## Operation
- State machine, states `BOOT`, `RUN`, `REFILL`.
  - Reset enters `BOOT`.
  - `BOOT` → `REFILL` on the first clock; `imem_addr=RESET_PC`.
  - `REFILL` → `RUN` after one cycle.
  - `RUN` → `REFILL` on any redirect.
- Next-PC priority, highest first:
  1. `initiate_exception` → `csr_mtvec`
  2. `mret` → `csr_mepc`
  3. `branch_taken` → `branch_target`
  4. `stall` → hold `FD_pc`
  5. otherwise `FD_pc+4`
- A trap overrides `stall`; `mret` and branch do not redirect while `stall=1`.
- Redirect is any of the first three rules. It forces `FD_bubble=1` and `XB_bubble=1` on the next edge, killing both the fetched-but-wrong FD instruction and the instruction entering XB.
- FD→XB update on `!stall`: `XB_pc<=FD_pc`, `XB_bubble<=FD_bubble|redirect`. On `stall`, XB holds.
- In `REFILL` and `BOOT`, `FD_bubble=1`. In `RUN`, `FD_bubble=0`.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC+4` wraps to 0 with no flag.
- Reset values:
  - `FD_pc=RESET_PC`, `XB_pc=0`
  - `FD_bubble=1`, `XB_bubble=1`
  - misaligned flag 0, state `BOOT`
- Reset asserted mid-redirect discards the redirect.

## Timing
- Redirect latency: redirect condition at edge N gives `imem_addr=target` before edge N, `FD_pc=target` after edge N, and the target instruction is valid in FD (`FD_bubble=0`) after edge N+1.
- Two bubbles enter XB per redirect.
- `imem_addr` is combinational from the inputs and state, with no registered delay. All other outputs are registered.
- Sequential throughput is 1 instruction/cycle in `RUN` without `stall`.

## Configuration
- `PC_MISALIGN_CHECK_EN` defined:
  - A branch/jump with `branch_target[1:0]!=0` does not redirect the fetch PC.
  - FD is flushed, and on the next edge XB is loaded with `XB_bubble=0`, `XB_pc=<PC of the branching instruction>` and `XB_FD_exception_instruction_misaligned=1`.
  - `csr_ehu` then traps with mcause 0 and mepc = the jump PC.
  - The flag clears on any other XB load.
- `PC_MISALIGN_CHECK_EN` undefined:
  - `branch_target[1:0]` is forced to 0.
  - The flag output is tied 0.

## Structure
- Shared package `core_pkg`:
  - state encoding `PCU_BOOT/RUN/REFILL`
  - `INSN_BYTES=4`
  - default reset PC constant
- One natural sub-module: `pc_next_mux`, combinational priority selector producing `imem_addr` and the `redirect` flag.
- The rest is stage registers plus the FSM in the top.

## Test plan
- Reset release, `RESET_PC=0` → `imem_addr` 0 in `BOOT`; `FD_pc` 0, 4, 8 in consecutive cycles; first `FD_bubble=0` one cycle after `FD_pc=0`; `XB_bubble` falls one cycle after that.
- Branch in XB at `XB_pc=0x10` to `0x100` → next `FD_pc=0x100` with `FD_bubble=1`; two XB bubbles; `XB_pc=0x100` valid two edges later.
- `initiate_exception` with `stall=1`, `csr_mtvec=0x4` → `FD_pc=0x4` next cycle regardless of stall; flush as a branch.
- Same-cycle `initiate_exception`, `mret` (`csr_mepc=0x200`) and `branch_taken` → PC goes to `csr_mtvec` only.
- `stall` held 3 cycles at `FD_pc=0x20` → `FD_pc`, `XB_pc` and `XB_bubble` are unchanged; resumes at `0x24`.
- Branch to `0x102`:
  - With `PC_MISALIGN_CHECK_EN` defined: `XB_FD_exception_instruction_misaligned=1`, `XB_pc` = branch PC, `FD_pc` not `0x102`.
  - With it undefined: `FD_pc=0x100` and the flag stays 0.
